// File: rtl/neck_pkg.sv
// Shared types and timing derivations for the posture alarm controller.
package neck_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMING = 2'd1,
    ALARM  = 2'd2,
    SNOOZE = 2'd3
  } state_t;

  localparam int MS_PER_S = 1000;

  function automatic int cycles_per_ms(input int clk_hz);
    return clk_hz / MS_PER_S;
  endfunction

  // Bits needed to count 0..n-1; never below one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Snooze-key debouncer: level accepted after DEBOUNCE_MS ticks of stability,
// a one-cycle key_press marks each debounced press (1->0).
module key_debounce
  import neck_pkg::*;
#(
  parameter int DEBOUNCE_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic key_n_sync,
  output logic key_press
);

  localparam int W = cnt_width(DEBOUNCE_MS);

  logic [W-1:0] cnt;
  logic         key_deb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      key_deb   <= 1'b1;
      key_press <= 1'b0;
    end else begin
      key_press <= 1'b0;
      // Any return to the accepted level restarts the stability window.
      if (key_n_sync == key_deb) begin
        cnt <= '0;
      end else if (tick) begin
        if (cnt == W'(DEBOUNCE_MS - 1)) begin
          cnt       <= '0;
          key_deb   <= key_n_sync;
          key_press <= ~key_n_sync;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alarm_ctrl.sv
// Posture alarm controller: arms on sustained bad posture, snoozes on key press.
// Optional ALARM_EVENT_CNT_EN adds a saturating alarm_cnt output.
module alarm_ctrl
  import neck_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int HOLD_MS     = 3000,
  parameter int SNOOZE_MS   = 10000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bad_posture,
  input  logic       key_n,
  output logic       alarm_en,
  output logic [1:0] state
`ifdef ALARM_EVENT_CNT_EN
  ,output logic [7:0] alarm_cnt
`endif
);

  localparam int CYC_PER_MS = cycles_per_ms(CLK_FREQ_HZ);
  localparam int TW         = cnt_width(CYC_PER_MS);
  localparam int MS_MAX     = (HOLD_MS > SNOOZE_MS) ? HOLD_MS : SNOOZE_MS;
  localparam int MW         = cnt_width(MS_MAX);

  logic [1:0]    bad_sync, key_sync;
  logic          bad, tick, key_press;
  logic [TW-1:0] tick_cnt;
  logic [MW-1:0] ms_cnt, ms_nxt;
  state_t        cur, nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bad_sync <= 2'b00;
      key_sync <= 2'b11;
    end else begin
      bad_sync <= {bad_sync[0], bad_posture};
      key_sync <= {key_sync[0], key_n};
    end
  end

  assign bad  = bad_sync[1];
  assign tick = (tick_cnt == TW'(CYC_PER_MS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= '0;
    else        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
  end

  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_key (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .key_n_sync(key_sync[1]),
    .key_press (key_press)
  );

  always_comb begin
    nxt    = cur;
    ms_nxt = ms_cnt;
    case (cur)
      IDLE: begin
        if (bad) begin
          nxt    = ARMING;
          ms_nxt = '0;
        end
      end
      ARMING: begin
        if (!bad) begin
          nxt = IDLE;
        end else if (tick) begin
          if (ms_cnt == MW'(HOLD_MS - 1)) nxt = ALARM;
          else                            ms_nxt = ms_cnt + 1'b1;
        end
      end
      ALARM: begin
        // Posture recovery outranks a simultaneous snooze request.
        if (!bad) begin
          nxt = IDLE;
        end else if (key_press) begin
          nxt    = SNOOZE;
          ms_nxt = '0;
        end
      end
      SNOOZE: begin
        if (key_press) begin
          ms_nxt = '0;
        end else if (tick) begin
          if (ms_cnt == MW'(SNOOZE_MS - 1)) nxt = IDLE;
          else                              ms_nxt = ms_cnt + 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur      <= IDLE;
      ms_cnt   <= '0;
      alarm_en <= 1'b0;
    end else begin
      cur      <= nxt;
      ms_cnt   <= ms_nxt;
      alarm_en <= (cur == ALARM);
    end
  end

  assign state = cur;

`ifdef ALARM_EVENT_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      alarm_cnt <= 8'd0;
    else if (cur == ARMING && nxt == ALARM && alarm_cnt != 8'hFF)
      alarm_cnt <= alarm_cnt + 8'd1;
  end
`endif

endmodule
